// File: rtl/phase_checker.sv
// Checks a 5-phase one-hot CPU phase bus: decodes the stage, counts retired instructions and latches the first error.
// Optional stall detection is built when PHASE_CHK_STALL_EN is defined.
module phase_checker #(
  parameter int CNT_W     = 16,
  parameter int STALL_MAX = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       phase,
  input  logic             clr_err,
  output logic [2:0]       phase_idx,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count,
  output logic             err,
  output logic [1:0]       err_code
);
  typedef enum logic [1:0] {INIT, TRACK, ERROR} state_t;

  localparam logic [1:0] E_NONE   = 2'b00;
  localparam logic [1:0] E_ONEHOT = 2'b01;
  localparam logic [1:0] E_SEQ    = 2'b10;
  localparam logic [1:0] E_STALL  = 2'b11;

  state_t           state, state_d;
  logic [4:0]       prev, prev_d;
  logic [2:0]       idx_d;
  logic             retire_d, err_d;
  logic [1:0]       code_d;
  logic [CNT_W-1:0] cnt_d;
  logic             one_hot, stall, hold_inc, hold_clr;
  logic [4:0]       rot_prev;

  assign one_hot  = (phase != 5'd0) && ((phase & (phase - 5'd1)) == 5'd0);
  assign rot_prev = {prev[3:0], prev[4]};

  always_comb begin
    idx_d = 3'd7;
    case (phase)
      5'b00001: idx_d = 3'd0;
      5'b00010: idx_d = 3'd1;
      5'b00100: idx_d = 3'd2;
      5'b01000: idx_d = 3'd3;
      5'b10000: idx_d = 3'd4;
      default:  idx_d = 3'd7;
    endcase
  end

`ifdef PHASE_CHK_STALL_EN
  localparam int HW = (STALL_MAX < 1) ? 1 : $clog2(STALL_MAX + 1);
  logic [HW-1:0] hold_cnt;

  // A hold is an error only once it would push the count past STALL_MAX.
  assign stall = (hold_cnt == HW'(STALL_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           hold_cnt <= '0;
    else if (hold_clr) hold_cnt <= '0;
    else if (hold_inc) hold_cnt <= hold_cnt + HW'(1);
  end
`else
  logic unused_hold;
  assign stall       = 1'b0;
  assign unused_hold = hold_inc ^ hold_clr ^ (STALL_MAX != 0);
`endif

  always_comb begin
    state_d  = state;
    prev_d   = prev;
    retire_d = 1'b0;
    cnt_d    = instr_count;
    err_d    = err;
    code_d   = err_code;
    hold_inc = 1'b0;
    hold_clr = 1'b0;
    if (clr_err) begin
      state_d  = INIT;
      prev_d   = 5'd0;
      err_d    = 1'b0;
      code_d   = E_NONE;
      hold_clr = 1'b1;
    end else begin
      case (state)
        INIT: begin
          if (phase == 5'b00001) begin
            state_d  = TRACK;
            prev_d   = phase;
            hold_clr = 1'b1;
          end else if (phase != 5'd0) begin
            state_d = ERROR;
            err_d   = 1'b1;
            code_d  = one_hot ? E_SEQ : E_ONEHOT;
          end
        end
        TRACK: begin
          if (!one_hot) begin
            state_d = ERROR;
            err_d   = 1'b1;
            code_d  = E_ONEHOT;
          end else if (phase == prev) begin
            if (stall) begin
              state_d = ERROR;
              err_d   = 1'b1;
              code_d  = E_STALL;
            end else begin
              hold_inc = 1'b1;
            end
          end else if (phase == rot_prev) begin
            prev_d   = phase;
            hold_clr = 1'b1;
            // WB -> IF closes one instruction
            if (prev[4]) begin
              retire_d = 1'b1;
              cnt_d    = instr_count + CNT_W'(1);
            end
          end else begin
            state_d = ERROR;
            err_d   = 1'b1;
            code_d  = E_SEQ;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= INIT;
      prev        <= 5'd0;
      phase_idx   <= 3'd7;
      retire      <= 1'b0;
      instr_count <= '0;
      err         <= 1'b0;
      err_code    <= E_NONE;
    end else begin
      state       <= state_d;
      prev        <= prev_d;
      phase_idx   <= idx_d;
      retire      <= retire_d;
      instr_count <= cnt_d;
      err         <= err_d;
      err_code    <= code_d;
    end
  end
endmodule

// File: doc/phase_checker.md
Name: phase_checker

Overview:
- Receiving end of the 5-phase one-hot CPU phase bus (IF/ID/EX/MEM/WB = 00001/00010/00100/01000/10000).
- Samples the phase bus every clock and verifies that each change is a legal one-hot rotation.
- Decodes the phase to a binary stage index, pulses once per retired instruction and keeps a retired-instruction count.
- Latches a sticky error with a cause code; sits beside the phase generator, and its outputs feed debug/LED logic.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- STALL_MAX, 255, maximum consecutive hold cycles before a stall error; used only with PHASE_CHK_STALL_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- phase  input  5  phase bus under check.
- clr_err  input  1  clears the sticky error and restarts checking.
- phase_idx  output  3  binary stage 0..4 of the last sampled phase; 7 = zero or invalid.
- retire  output  1  one-cycle pulse on each legal 10000->00001 transition.
- instr_count  output  CNT_W  retired-instruction count; wraps modulo 2^CNT_W.
- err  output  1  sticky error flag.
- err_code  output  2  00 none, 01 not one-hot, 10 illegal sequence/start, 11 stall.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=INIT, prev=00000, phase_idx=7, retire=0, instr_count=0, err=0, err_code=00, hold counter=0.
- Timing: all outputs are registered. The sample taken at edge k is reflected in the outputs immediately after edge k (1-cycle latency from the phase input).
- Definitions:
  - rot(p) = {p[3:0], p[4]}.
  - one-hot = exactly one bit set; 00000 is not one-hot.
- phase_idx: updated every cycle in every state, from the sampled phase.
- State INIT:
  - phase=00000: stay in INIT.
  - phase=00001: go to TRACK; prev<=phase.
  - Other one-hot value: go to ERROR, code 10.
  - Not one-hot: go to ERROR, code 01.
- State TRACK:
  - phase=prev: hold; stay.
  - phase=rot(prev): advance; prev<=phase. If prev=10000, assert retire for 1 cycle and increment instr_count.
  - phase not one-hot (including 00000): go to ERROR, code 01.
  - One-hot but neither hold nor advance (skip or backward step): go to ERROR, code 10.
- State ERROR:
  - err=1; err_code frozen at the first cause.
  - retire=0; instr_count frozen.
  - Further bad phases are ignored.
- clr_err, any state:
  - Next state INIT; prev<=00000; err<=0; err_code<=00; hold counter cleared.
  - Takes priority over error detection in the same cycle.
  - instr_count is not cleared.
- Error entry: err and err_code become visible in the same cycle as the offending sample's phase_idx.
- Counter wrap: instr_count at 2^CNT_W-1 wraps to 0 on the next retire; no flag.
- Reset mid-operation: immediate return to reset values regardless of state.

Optional Feature:
- Macro: PHASE_CHK_STALL_EN.
- Defined:
  - In TRACK, a hold counter increments on each hold cycle and clears on each advance.
  - When a hold would make the count exceed STALL_MAX, go to ERROR, code 11.
  - A phase bus held for exactly STALL_MAX cycles is still legal.
- Not defined:
  - No hold counter is built; holds are unlimited.
  - Code 11 is never produced.

Test Plan:
- Reset, then phase 00000 for 3 cycles, then 00001,00010,00100,01000,10000,00001 -> phase_idx 7,7,7,0,1,2,3,4,0; retire pulses once, after the final 00001; instr_count=1; err=0.
- 20 full rotations with random 0-3 hold cycles between steps (macro off) -> instr_count=20; err=0.
- In TRACK at 00100, drive 10000 -> err=1, err_code=10 one cycle later. Pulse clr_err, then drive 00001 -> err=0, state TRACK, instr_count unchanged.
- In TRACK, drive 00110, then 00000 -> err_code=01 latched from 00110; stays 01 after 00000.
- After reset, first phase 00100 -> err_code=10. Assert clr_err in the same cycle as bad phase 11111 -> err stays 0, state INIT.
- PHASE_CHK_STALL_EN, STALL_MAX=4: hold 00010 for 4 cycles, advance -> no error. Hold 00100 for 5 cycles -> err_code=11 on the 5th hold. Assert rst mid-hold on a repeat run -> all outputs at reset values.
